// File: rtl/vga_timing_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_if                                                   |
// | Brief    : Bundle of pixel-enable, sync, coordinate, tile-address, pulse   |
// |            and interrupt signals between the VGA timing generator (master) |
// |            and its consumers (slave).                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface vga_timing_if #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              irq_clr;
  logic              vga_HS;
  logic              vga_VS;
  logic              vga_DA;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic [ADDR_W-1:0] vaddr;
  logic              vaddr_valid;
  logic              line_start;
  logic              frame_start;
  logic              irq;

  // The timing generator consumes en/irq_clr and drives everything else.
  modport master (
    input  en, irq_clr,
    output vga_HS, vga_VS, vga_DA, x, y, vaddr, vaddr_valid,
           line_start, frame_start, irq
  );

  // A consumer of the timing (pixel pipeline, CPU interrupt logic).
  modport slave (
    output en, irq_clr,
    input  vga_HS, vga_VS, vga_DA, x, y, vaddr, vaddr_valid,
           line_start, frame_start, irq
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing                                                      |
// | Brief    : VGA raster timing generator. Free-running h/v counters gated by |
// |            a pixel enable, registered sync/active-video/coordinate outputs,|
// |            tile-grid address generation, line/frame start pulses and an    |
// |            optional sticky vblank interrupt.                               |
// | Options  : define VGA_VBLANK_IRQ_EN to build the vblank interrupt;         |
// |            otherwise irq is tied low and irq_clr is ignored.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CNT_W      = 11,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int TILE_SHIFT = 6,
  parameter int GRID_COLS  = 10,
  parameter int GRID_ROWS  = 8,
  parameter int ADDR_W     = 8,
  parameter int ADDR_BASE  = 128
) (
  input  wire logic    clk,
  input  wire logic    reset,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0]  c_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  c_V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  c_H_ACTIVE   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  c_V_ACTIVE   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  c_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]  c_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  c_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]  c_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0]  c_GRID_COLS  = CNT_W'(GRID_COLS);
  localparam logic [CNT_W-1:0]  c_GRID_ROWS  = CNT_W'(GRID_ROWS);
  localparam logic [ADDR_W-1:0] c_GRID_COLS_A = ADDR_W'(GRID_COLS);
  localparam logic [ADDR_W-1:0] c_ADDR_BASE  = ADDR_W'(ADDR_BASE);
  localparam logic              c_HS_ON      = (HS_POL != 0);
  localparam logic              c_VS_ON      = (VS_POL != 0);

  // Raster position counters
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             w_h_wrap;

  // Registered outputs and their next-state values
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              da_q, da_d;
  logic [CNT_W-1:0]  x_q, y_q;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              valid_q, valid_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  logic              irq_q;

  // Tile decode helpers
  logic [CNT_W-1:0]  w_col;
  logic [CNT_W-1:0]  w_row;
  logic [ADDR_W-1:0] w_tile_addr;

  // Next raster position: h wraps every line, v steps only on the h wrap.
  always_comb begin
    w_h_wrap = (h_q == c_H_LAST);
    h_d      = w_h_wrap ? '0 : (h_q + c_ONE);
    v_d      = v_q;
    if (w_h_wrap) begin
      v_d = (v_q == c_V_LAST) ? '0 : (v_q + c_ONE);
    end
  end

  // Counter state; reset forces the origin even when the pixel enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (bus.en) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode the current position into the values the outputs take next en-cycle.
  always_comb begin
    w_col       = h_q >> TILE_SHIFT;
    w_row       = v_q >> TILE_SHIFT;
    da_d        = (h_q < c_H_ACTIVE) && (v_q < c_V_ACTIVE);
    hs_d        = ((h_q >= c_HS_START) && (h_q < c_HS_END)) ? c_HS_ON : ~c_HS_ON;
    vs_d        = ((v_q >= c_VS_START) && (v_q < c_VS_END)) ? c_VS_ON : ~c_VS_ON;
    valid_d     = da_d && (w_col < c_GRID_COLS) && (w_row < c_GRID_ROWS);
    // Narrowing row/col before the arithmetic is harmless: the sum wraps modulo 2^ADDR_W anyway.
    w_tile_addr = c_ADDR_BASE + (ADDR_W'(w_row) * c_GRID_COLS_A) + ADDR_W'(w_col);
    vaddr_d     = valid_d ? w_tile_addr : c_ADDR_BASE;
    ls_d        = (h_q == '0);
    fs_d        = (h_q == '0) && (v_q == '0);
  end

  // Output registers; pulses are held along with everything else while en is low,
  // so a consumer qualifying them with en sees each pulse exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= ~c_HS_ON;
      vs_q    <= ~c_VS_ON;
      da_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vaddr_q <= c_ADDR_BASE;
      valid_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (bus.en) begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      da_q    <= da_d;
      x_q     <= h_q;
      y_q     <= v_q;
      vaddr_q <= vaddr_d;
      valid_q <= valid_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_VBLANK_IRQ_EN
  logic w_irq_set;

  assign w_irq_set = bus.en && (h_q == '0) && (v_q == c_V_ACTIVE);

  // Sticky vblank flag; a set in the same cycle as a clear wins so no vblank is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (w_irq_set) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end
`else
  logic w_unused_irq_clr;

  assign w_unused_irq_clr = bus.irq_clr;
  assign irq_q            = 1'b0;
`endif

  assign bus.vga_HS      = hs_q;
  assign bus.vga_VS      = vs_q;
  assign bus.vga_DA      = da_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.vaddr       = vaddr_q;
  assign bus.vaddr_valid = valid_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing                                                   |
// | Brief    : Directed self-checking bench for vga_timing. Instance A uses    |
// |            the default 640x480 timing; instance B uses a miniature raster  |
// |            (24x16 totals) so whole frames, vsync and vblank fit in budget. |
// |            Irq expectations follow VGA_VBLANK_IRQ_EN.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_timing;

`ifdef VGA_VBLANK_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_timing_if #(.CNT_W(11), .ADDR_W(8)) bus_a ();
  vga_timing_if #(.CNT_W(11), .ADDR_W(8)) bus_b ();

  vga_timing u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.master)
  );

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CNT_W(11), .HS_POL(1), .VS_POL(0), .TILE_SHIFT(2),
    .GRID_COLS(3), .GRID_ROWS(2), .ADDR_W(8), .ADDR_BASE(5)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase A bookkeeping
  int hs_low, hs_min, hs_max, da_cnt, ls_cnt, fs_cnt, pos_err;
  // Phase B bookkeeping
  logic hs_b [24];
  logic vs_b [16];
  int   fs_first, fs_second, ls_b;
  logic [31:0] va_11_7, vv_11_7, va_12_7, vv_12_7, da_12_7, va_11_8, vv_11_8, va_5_5, vv_5_5;
  logic irq_pre, irq_set, irq_end;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.en = 1'b1;
    bus_a.irq_clr = 1'b0;
    bus_b.en = 1'b0;
    bus_b.irq_clr = 1'b0;
    tick();
    tick();

    // ---------------- Instance A: reset state ----------------
    check("a_rst_da",    bus_a.vga_DA, 0);
    check("a_rst_hs",    bus_a.vga_HS, 1);
    check("a_rst_vs",    bus_a.vga_VS, 1);
    check("a_rst_x",     bus_a.x, 0);
    check("a_rst_y",     bus_a.y, 0);
    check("a_rst_vaddr", bus_a.vaddr, 128);
    check("a_rst_valid", bus_a.vaddr_valid, 0);
    check("a_rst_ls",    bus_a.line_start, 0);
    check("a_rst_fs",    bus_a.frame_start, 0);
    check("a_rst_irq",   bus_a.irq, 0);

    // ---------------- Instance A: first line ----------------
    rst_a = 1'b0;
    hs_low = 0; hs_min = 99999; hs_max = -1;
    da_cnt = 0; ls_cnt = 0; fs_cnt = 0; pos_err = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (i == 0) begin
        check("a_first_fs",    bus_a.frame_start, 1);
        check("a_first_ls",    bus_a.line_start, 1);
        check("a_first_da",    bus_a.vga_DA, 1);
        check("a_first_vaddr", bus_a.vaddr, 128);
        check("a_first_valid", bus_a.vaddr_valid, 1);
      end
      if (bus_a.vga_HS == 1'b0) begin
        hs_low++;
        if (int'(bus_a.x) < hs_min) hs_min = int'(bus_a.x);
        if (int'(bus_a.x) > hs_max) hs_max = int'(bus_a.x);
      end
      if (bus_a.vga_DA) da_cnt++;
      if (bus_a.line_start) ls_cnt++;
      if (bus_a.frame_start) fs_cnt++;
      if (int'(bus_a.x) != i || bus_a.y != 11'd0) pos_err++;
    end
    check("a_hs_low_cnt", hs_low, 96);
    check("a_hs_min_x",   hs_min, 656);
    check("a_hs_max_x",   hs_max, 751);
    check("a_da_cnt",     da_cnt, 640);
    check("a_ls_cnt",     ls_cnt, 1);
    check("a_fs_cnt",     fs_cnt, 1);
    check("a_pos_err",    pos_err, 0);

    tick();
    check("a_l1_x",  bus_a.x, 0);
    check("a_l1_y",  bus_a.y, 1);
    check("a_l1_ls", bus_a.line_start, 1);
    check("a_l1_fs", bus_a.frame_start, 0);

    // ---------------- Instance A: tile addresses on line 70 ----------------
    repeat (69 * 800 + 130) tick();
    check("a_130_70_x",     bus_a.x, 130);
    check("a_130_70_y",     bus_a.y, 70);
    check("a_130_70_vaddr", bus_a.vaddr, 140);
    check("a_130_70_valid", bus_a.vaddr_valid, 1);
    repeat (509) tick();
    check("a_639_70_x",     bus_a.x, 639);
    check("a_639_70_vaddr", bus_a.vaddr, 147);
    check("a_639_70_valid", bus_a.vaddr_valid, 1);
    tick();
    check("a_640_70_x",     bus_a.x, 640);
    check("a_640_70_vaddr", bus_a.vaddr, 128);
    check("a_640_70_valid", bus_a.vaddr_valid, 0);
    check("a_640_70_da",    bus_a.vga_DA, 0);

    // ---------------- Instance A: en low freezes outputs ----------------
    bus_a.en = 1'b0;
    repeat (3) tick();
    check("a_hold_x",     bus_a.x, 640);
    check("a_hold_y",     bus_a.y, 70);
    check("a_hold_vaddr", bus_a.vaddr, 128);
    bus_a.en = 1'b1;
    tick();
    check("a_resume_x", bus_a.x, 641);

    // ---------------- Instance A: mid-frame reset at counter (300,71) ----------------
    repeat (458) tick();
    check("a_pre_rst_x", bus_a.x, 299);
    check("a_pre_rst_y", bus_a.y, 71);
    rst_a = 1'b1;
    tick();
    check("a_mid_rst_x",  bus_a.x, 0);
    check("a_mid_rst_fs", bus_a.frame_start, 0);
    check("a_mid_rst_hs", bus_a.vga_HS, 1);
    rst_a = 1'b0;
    tick();
    check("a_post_rst_x",  bus_a.x, 0);
    check("a_post_rst_y",  bus_a.y, 0);
    check("a_post_rst_fs", bus_a.frame_start, 1);

    // Reset while en is low still returns to the origin.
    repeat (10) tick();
    bus_a.en = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    bus_a.en = 1'b1;
    tick();
    check("a_rst_en0_x",  bus_a.x, 0);
    check("a_rst_en0_fs", bus_a.frame_start, 1);

    // ---------------- Instance B: full frame on the miniature raster ----------------
    bus_b.en = 1'b1;
    tick();
    rst_b = 1'b0;
    fs_first = -1; fs_second = -1; ls_b = 0;
    for (int k = 1; k <= 385; k++) begin
      tick();
      if (bus_b.frame_start) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k <= 384 && bus_b.line_start) ls_b++;
      if (bus_b.y == 11'd0 && bus_b.x < 11'd24) hs_b[int'(bus_b.x)] = bus_b.vga_HS;
      if (bus_b.x == 11'd0 && bus_b.y < 11'd16) vs_b[int'(bus_b.y)] = bus_b.vga_VS;
      if (bus_b.x == 11'd11 && bus_b.y == 11'd7) begin va_11_7 = 32'(bus_b.vaddr); vv_11_7 = 32'(bus_b.vaddr_valid); end
      if (bus_b.x == 11'd12 && bus_b.y == 11'd7) begin
        va_12_7 = 32'(bus_b.vaddr); vv_12_7 = 32'(bus_b.vaddr_valid); da_12_7 = 32'(bus_b.vga_DA);
      end
      if (bus_b.x == 11'd11 && bus_b.y == 11'd8) begin va_11_8 = 32'(bus_b.vaddr); vv_11_8 = 32'(bus_b.vaddr_valid); end
      if (bus_b.x == 11'd5 && bus_b.y == 11'd5) begin va_5_5 = 32'(bus_b.vaddr); vv_5_5 = 32'(bus_b.vaddr_valid); end
      if (bus_b.x == 11'd23 && bus_b.y == 11'd9) irq_pre = bus_b.irq;
      if (bus_b.x == 11'd0 && bus_b.y == 11'd10) irq_set = bus_b.irq;
      if (bus_b.x == 11'd23 && bus_b.y == 11'd15) irq_end = bus_b.irq;
    end
    check("b_fs_first",  fs_first, 1);
    check("b_fs_second", fs_second, 385);
    check("b_ls_cnt",    ls_b, 16);
    check("b_hs_x17",    hs_b[17], 0);
    check("b_hs_x18",    hs_b[18], 1);
    check("b_hs_x20",    hs_b[20], 1);
    check("b_hs_x21",    hs_b[21], 0);
    check("b_vs_y11",    vs_b[11], 1);
    check("b_vs_y12",    vs_b[12], 0);
    check("b_vs_y13",    vs_b[13], 0);
    check("b_vs_y14",    vs_b[14], 1);
    check("b_va_11_7",   va_11_7, 10);
    check("b_vv_11_7",   vv_11_7, 1);
    check("b_va_12_7",   va_12_7, 5);
    check("b_vv_12_7",   vv_12_7, 0);
    check("b_da_12_7",   da_12_7, 1);
    check("b_va_11_8",   va_11_8, 5);
    check("b_vv_11_8",   vv_11_8, 0);
    check("b_va_5_5",    va_5_5, 9);
    check("b_vv_5_5",    vv_5_5, 1);
    check("b_irq_pre",   irq_pre, 0);
    check("b_irq_set",   irq_set, IRQ_ON);
    check("b_irq_end",   irq_end, IRQ_ON);
    check("b_irq_sticky", bus_b.irq, IRQ_ON);

    // Clear while en is low: irq drops, position holds.
    bus_b.en = 1'b0;
    bus_b.irq_clr = 1'b1;
    tick();
    bus_b.irq_clr = 1'b0;
    check("b_irq_clr_en0", bus_b.irq, 0);
    check("b_hold_x",      bus_b.x, 0);
    check("b_hold_y",      bus_b.y, 0);

    // Clear coincident with the vblank set: set wins.
    bus_b.en = 1'b1;
    repeat (9 * 24 + 23) tick();
    check("b_pre2_x",   bus_b.x, 23);
    check("b_pre2_y",   bus_b.y, 9);
    check("b_pre2_irq", bus_b.irq, 0);
    bus_b.irq_clr = 1'b1;
    tick();
    bus_b.irq_clr = 1'b0;
    check("b_coinc_y",   bus_b.y, 10);
    check("b_coinc_irq", bus_b.irq, IRQ_ON);
    tick();
    check("b_coinc_irq_hold", bus_b.irq, IRQ_ON);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
